arbiter_hold_rr: RTL and testbench

- Parametrised successor to the NUMUNITS arbiter; sits behind the existing arbiter interface signal set (roundORpriority, request, priorit, grant).
- Adds multi-cycle grant hold with a bounded burst (MAX_HOLD) and zero-bubble handoff.
- Adds a registered grant index and valid flag.
- Selectable per arbitration between round-robin and programmable fixed priority.

---
 rtl/arbiter_hold_rr_if.sv | 22 ++
 rtl/arbiter_hold_rr.sv | 148 ++++++++++++++
 tb/tb_arbiter_hold_rr.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_hold_rr_if.sv
// Arbiter handshake bundle: mode, requests and priorities in; registered grant out.
interface arbiter_hold_rr_if #(
   parameter int NUM_UNITS = 4,
   parameter int ADDR_WD   = 2
);
   logic                         roundORpriority;
   logic [NUM_UNITS-1:0]         request;
   logic [ADDR_WD*NUM_UNITS-1:0] priorit;
   logic [NUM_UNITS-1:0]         grant;
   logic                         grant_valid;
   logic [ADDR_WD-1:0]           grant_id;

   modport master (
      output roundORpriority, request, priorit,
      input  grant, grant_valid, grant_id
   );

   modport slave (
      input  roundORpriority, request, priorit,
      output grant, grant_valid, grant_id
   );
endinterface

// File: rtl/arbiter_hold_rr.sv
// Hold-capable RR / fixed-priority arbiter with bounded bursts and zero-bubble handoff.
// Optional request aging (priority mode) is enabled by defining ARB_AGING_EN.
module arbiter_hold_rr #(
   parameter int NUM_UNITS = 4,
   parameter int ADDR_WD   = 2,
   parameter int MAX_HOLD  = 8,
   parameter int AGE_LIMIT = 16
) (
   input logic              clock,
   input logic              rst,
   arbiter_hold_rr_if.slave bus
);
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic {IDLE, GRANTED} state_e;

   state_e               state_q, state_d;
   logic [NUM_UNITS-1:0] grant_q, grant_d;
   logic [ADDR_WD-1:0]   id_q, id_d;
   logic [ADDR_WD-1:0]   last_q, last_d;
   logic [HW-1:0]        hold_q, hold_d;

   logic                 h_req;
   logic                 at_lim;
   logic [NUM_UNITS-1:0] cand;
   logic [ADDR_WD-1:0]   win;
   logic                 win_any;
   logic [ADDR_WD-1:0]   best;

`ifdef ARB_AGING_EN
   localparam int AW = $clog2(AGE_LIMIT + 1);

   logic [AW-1:0]        age_q [NUM_UNITS];
   logic [AW-1:0]        age_d [NUM_UNITS];
   logic [NUM_UNITS-1:0] aged;

   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         aged[i]  = (age_q[i] == AW'(AGE_LIMIT));
         age_d[i] = age_q[i];
         if (!bus.request[i] || grant_q[i])
            age_d[i] = '0;
         else if (!aged[i])
            age_d[i] = age_q[i] + AW'(1);
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (rst) age_q[i] <= '0;
         else     age_q[i] <= age_d[i];
      end
   end
`endif

   assign h_req  = |(bus.request & grant_q);
   assign at_lim = (hold_q == HW'(MAX_HOLD - 1));

   // Winner search; the current holder is excluded only when its burst is spent.
   always_comb begin
      cand    = bus.request;
      win     = '0;
      win_any = 1'b0;
      best    = '0;
      if (state_q == GRANTED && h_req && at_lim)
         cand = bus.request & ~grant_q;
      if (bus.roundORpriority) begin
         for (int off = 1; off <= NUM_UNITS; off++) begin
            if (!win_any && cand[(int'(last_q) + off) % NUM_UNITS]) begin
               win_any = 1'b1;
               win     = ADDR_WD'((int'(last_q) + off) % NUM_UNITS);
            end
         end
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (cand[i] &&
                (!win_any || bus.priorit[i*ADDR_WD +: ADDR_WD] > best)) begin
               win_any = 1'b1;
               win     = ADDR_WD'(i);
               best    = bus.priorit[i*ADDR_WD +: ADDR_WD];
            end
         end
`ifdef ARB_AGING_EN
         for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (cand[i] && aged[i])
               win = ADDR_WD'(i);
         end
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d = GRANTED;
               grant_d = NUM_UNITS'(1) << win;
               id_d    = win;
               last_d  = win;
               hold_d  = '0;
            end
         end
         GRANTED: begin
            if (h_req && !at_lim) begin
               hold_d = hold_q + HW'(1);
            end else if (win_any) begin
               grant_d = NUM_UNITS'(1) << win;
               id_d    = win;
               last_d  = win;
               hold_d  = '0;
            end else if (h_req) begin
               hold_d = '0;
            end else begin
               state_d = IDLE;
               grant_d = '0;
               id_d    = '0;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         id_q    <= '0;
         last_q  <= ADDR_WD'(NUM_UNITS - 1);
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = |grant_q;
   assign bus.grant_id    = id_q;
endmodule

// File: tb/tb_arbiter_hold_rr.sv
// Directed bench for arbiter_hold_rr: reset, RR handoff, priority, hold limit,
// mode change and starvation/aging.
module tb_arbiter_hold_rr;
   logic clk;
   logic rst;
   int   vectors;
   int   errors;

   arbiter_hold_rr_if #(.NUM_UNITS(4), .ADDR_WD(2)) bus ();

   arbiter_hold_rr #(
      .NUM_UNITS(4), .ADDR_WD(2), .MAX_HOLD(8), .AGE_LIMIT(16)
   ) dut (
      .clock(clk),
      .rst  (rst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic mode, input logic [7:0] pri,
                           input logic [3:0] req);
      rst = 1'b1;
      bus.roundORpriority = mode;
      bus.priorit = pri;
      bus.request = req;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.roundORpriority = 1'b1;
      bus.priorit = 8'h00;
      bus.request = 4'b1111;
      for (int k = 0; k < 2; k++) begin
         step();
         vectors++;
         if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 ||
             bus.grant_id !== 2'd0) begin
            $display("FAIL reset[%0d]: grant=%b valid=%b id=%0d, want 0000/0/0",
                     k, bus.grant, bus.grant_valid, bus.grant_id);
            errors++;
         end
      end
      rst = 1'b0;
      step();
      vectors++;
      if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1 ||
          bus.grant_id !== 2'd0) begin
         $display("FAIL reset_release: grant=%b valid=%b id=%0d, want 0001/1/0",
                  bus.grant, bus.grant_valid, bus.grant_id);
         errors++;
      end
   endtask

   task automatic test_rr_handoff();
      logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] eid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset(1'b1, 8'h00, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         step();
         vectors++;
         if (bus.grant !== exp[k] || bus.grant_id !== eid[k]) begin
            $display("FAIL rr_handoff[%0d]: grant=%b id=%0d, want %b id=%0d",
                     k, bus.grant, bus.grant_id, exp[k], eid[k]);
            errors++;
         end
         bus.request = 4'b1111 & ~exp[k];
      end
   endtask

   task automatic test_priority();
      logic [3:0] exp [5] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0000};
      logic [1:0] eid [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
      do_reset(1'b0, 8'b00_10_01_11, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         step();
         vectors++;
         if (bus.grant !== exp[k] || bus.grant_id !== eid[k] ||
             bus.grant_valid !== (|exp[k])) begin
            $display("FAIL priority[%0d]: grant=%b id=%0d valid=%b, want %b id=%0d",
                     k, bus.grant, bus.grant_id, bus.grant_valid, exp[k], eid[k]);
            errors++;
         end
         bus.request = bus.request & ~exp[k];
      end
      do_reset(1'b0, 8'b01_01_01_01, 4'b1010);
      step();
      vectors++;
      if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
         $display("FAIL priority_tie: grant=%b id=%0d, want 0010 id=1",
                  bus.grant, bus.grant_id);
         errors++;
      end
   endtask

   task automatic test_hold_limit();
      logic [3:0] exp;
      do_reset(1'b1, 8'h00, 4'b0011);
      for (int c = 0; c < 32; c++) begin
         step();
         exp = ((c / 8) % 2 == 1) ? 4'b0010 : 4'b0001;
         vectors++;
         if (bus.grant !== exp) begin
            $display("FAIL hold_alt[%0d]: grant=%b, want %b", c, bus.grant, exp);
            errors++;
         end
      end
      rst = 1'b1;
      step();
      vectors++;
      if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
         $display("FAIL mid_grant_reset: grant=%b valid=%b, want 0000/0",
                  bus.grant, bus.grant_valid);
         errors++;
      end
      rst = 1'b0;
      bus.request = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         step();
         vectors++;
         if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1) begin
            $display("FAIL hold_alone[%0d]: grant=%b valid=%b, want 0001/1",
                     c, bus.grant, bus.grant_valid);
            errors++;
         end
      end
   endtask

   task automatic test_mode_change();
      do_reset(1'b1, 8'h00, 4'b0100);
      step();
      vectors++;
      if (bus.grant !== 4'b0100) begin
         $display("FAIL mode_first: grant=%b, want 0100", bus.grant);
         errors++;
      end
      bus.roundORpriority = 1'b0;
      bus.priorit = 8'b00_00_11_01;
      bus.request = 4'b0111;
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++;
         if (bus.grant !== 4'b0100) begin
            $display("FAIL mode_keep[%0d]: grant=%b, want 0100", c, bus.grant);
            errors++;
         end
      end
      bus.request = 4'b0011;
      step();
      vectors++;
      if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
         $display("FAIL mode_next: grant=%b id=%0d, want 0010 id=1",
                  bus.grant, bus.grant_id);
         errors++;
      end
   endtask

   task automatic test_starvation();
      logic seen;
      seen = 1'b0;
      do_reset(1'b0, 8'b00_01_10_11, 4'b1111);
      for (int c = 0; c < 64; c++) begin
         step();
         if (bus.grant[3]) seen = 1'b1;
         vectors++;
         if ($countones(bus.grant) != 1) begin
            $display("FAIL onehot[%0d]: grant=%b, want exactly one bit", c, bus.grant);
            errors++;
         end
      end
      vectors++;
`ifdef ARB_AGING_EN
      if (seen !== 1'b1) begin
         $display("FAIL aging_u3: granted=%b, want 1", seen);
         errors++;
      end
`else
      if (seen !== 1'b0) begin
         $display("FAIL starve_u3: granted=%b, want 0", seen);
         errors++;
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vectors = 0;
      errors  = 0;
      rst = 1'b1;
      bus.roundORpriority = 1'b1;
      bus.priorit = 8'h00;
      bus.request = 4'b0000;
      test_reset();
      test_rr_handoff();
      test_priority();
      test_hold_limit();
      test_mode_change();
      test_starvation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
